// File: rtl/wb_pkg.sv
// Shared constants and types for the register-file writeback stage.
package wb_pkg;
  localparam int SRC_ALU   = 0;
  localparam int SRC_CONST = 1;
  localparam int SRC_LOAD  = 2;
  localparam int SRC_PC4   = 3;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} wb_state_e;
endpackage

// File: rtl/load_align.sv
// Sub-word load extraction with sign/zero extension; full words pass through.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [2:0]      fmt,
  input  logic [1:0]      byte_off,
  output logic [XLEN-1:0] data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = word[{byte_off, 3'b000} +: 8];
    w_half = byte_off[1] ? word[31:16] : word[15:0];
    case (fmt)
      LD_B:    data = {{(XLEN-8){w_byte[7]}}, w_byte};
      LD_BU:   data = {{(XLEN-8){1'b0}}, w_byte};
      LD_H:    data = {{(XLEN-16){w_half[15]}}, w_half};
      LD_HU:   data = {{(XLEN-16){1'b0}}, w_half};
      default: data = word;
    endcase
  end
endmodule

// File: rtl/writeback_stage.sv
// Writeback source select, load formatting and a 2-entry skid queue with
// forwarding from queued entries toward the register-file write port.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NSRC     = 4,
  parameter int REGW     = 5,
  parameter int LOAD_SRC = SRC_LOAD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NSRC*XLEN-1:0]     src_data,
  input  logic [$clog2(NSRC)-1:0]  src_sel,
  input  logic [2:0]               load_fmt,
  input  logic [1:0]               byte_off,
  input  logic [REGW-1:0]          rd_addr,
  input  logic                     rd_we,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [REGW-1:0]          out_addr,
  output logic [XLEN-1:0]          out_data,
  input  logic [REGW-1:0]          fwd_raddr,
  output logic                     fwd_hit,
  output logic [XLEN-1:0]          fwd_data,
  output logic [1:0]               occupancy
);
  localparam int SELW = $clog2(NSRC);
  localparam logic [SELW-1:0] LOAD_SEL = SELW'(LOAD_SRC);

  wb_state_e       r_state;
  logic [REGW-1:0] r_addr0, r_addr1;
  logic [XLEN-1:0] r_data0, r_data1;

  logic [XLEN-1:0] w_sel_data, w_fmt_data, w_wr_data;
  logic            w_push, w_pop;

  // Selects beyond NSRC match no source and leave the data at zero.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_sel == SELW'(i)) w_sel_data = src_data[i*XLEN +: XLEN];
    end
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .word     (w_sel_data),
    .fmt      (load_fmt),
    .byte_off (byte_off),
    .data     (w_fmt_data)
  );

  assign w_wr_data = (src_sel == LOAD_SEL) ? w_fmt_data : w_sel_data;
  assign in_ready  = (r_state != TWO) && rst_n;
  assign out_valid = (r_state != EMPTY);
  assign out_addr  = r_addr0;
  assign out_data  = r_data0;
  assign occupancy = (r_state == TWO) ? 2'd2 : (r_state == ONE) ? 2'd1 : 2'd0;
  // Null writes are handshaken but never enter the queue.
  assign w_push    = in_valid && in_ready && rd_we && (rd_addr != '0);
  assign w_pop     = out_valid && out_ready;

  // Slot 0 is always the oldest entry; slot 1 only holds data in TWO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_addr0 <= '0;
      r_data0 <= '0;
      r_addr1 <= '0;
      r_data1 <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_addr0 <= rd_addr;
            r_data0 <= w_wr_data;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (w_push && !w_pop) begin
            r_addr1 <= rd_addr;
            r_data1 <= w_wr_data;
            r_state <= TWO;
          end else if (w_push && w_pop) begin
            r_addr0 <= rd_addr;
            r_data0 <= w_wr_data;
          end else if (w_pop) begin
            r_state <= EMPTY;
          end
        end
        TWO: begin
          if (w_pop) begin
            r_addr0 <= r_addr1;
            r_data0 <= r_data1;
            r_state <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  // Newest entry is checked last so it overrides an older match.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_raddr != '0) begin
      if (r_state != EMPTY && r_addr0 == fwd_raddr) begin
        fwd_hit  = 1'b1;
        fwd_data = r_data0;
      end
      if (r_state == TWO && r_addr1 == fwd_raddr) begin
        fwd_hit  = 1'b1;
        fwd_data = r_data1;
      end
    end
  end
endmodule

// File: tb/tb_writeback_stage.sv
// Randomised and directed bench for writeback_stage against a queue-based model.
module tb_writeback_stage;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [127:0] src_data;
  logic [1:0]   src_sel;
  logic [2:0]   load_fmt;
  logic [1:0]   byte_off;
  logic [4:0]   rd_addr;
  logic         rd_we;
  logic         out_valid, out_ready;
  logic [4:0]   out_addr;
  logic [31:0]  out_data;
  logic [4:0]   fwd_raddr;
  logic         fwd_hit;
  logic [31:0]  fwd_data;
  logic [1:0]   occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .src_data(src_data), .src_sel(src_sel), .load_fmt(load_fmt),
    .byte_off(byte_off), .rd_addr(rd_addr), .rd_we(rd_we),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit),
    .fwd_data(fwd_data), .occupancy(occupancy)
  );

  // Reference formatting from the load rules, using plain arithmetic.
  function automatic logic [31:0] ref_data(logic [127:0] src, int sel,
                                           logic [2:0] fmt, int off);
    logic [31:0] w;
    longint unsigned b, h;
    if (sel >= 4) return 32'h0;
    w = src[sel*32 +: 32];
    if (sel != 2) return w;
    b = (longint'(w) >> (8 * off)) % 256;
    h = (longint'(w) >> (16 * (off / 2))) % 65536;
    case (fmt)
      3'b000:  return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
      3'b100:  return 32'(b);
      3'b001:  return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
      3'b101:  return 32'(h);
      default: return w;
    endcase
  endfunction

  task automatic drive(input logic v, input int sel, input logic [31:0] d,
                       input logic [2:0] fmt, input int off, input int addr,
                       input logic we, input logic ordy);
    in_valid  = v;
    src_sel   = 2'(sel);
    src_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    src_data[sel*32 +: 32] = d;
    load_fmt  = fmt;
    byte_off  = 2'(off);
    rd_addr   = 5'(addr);
    rd_we     = we;
    out_ready = ordy;
  endtask

  // Advance one clock and update the model with the handshakes that happened.
  task automatic tick();
    bit          acc, pop;
    logic [31:0] d;
    acc = in_valid && (q.size() < 2);
    pop = (q.size() > 0) && out_ready;
    d   = ref_data(src_data, int'(src_sel), load_fmt, int'(byte_off));
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc && rd_we && rd_addr != 0) q.push_back('{a: rd_addr, d: d});
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 3'b010, 0, 0, 0, 0);
    fwd_raddr = 5'd0;
    #12;
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    n_tests++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || fwd_hit !== 1'b0) begin
      n_fail++; $display("FAIL reset_state valid %b occ %0d hit %b exp 0", out_valid, occupancy, fwd_hit);
    end
    n_tests++;
    if (out_addr !== 5'd0 || out_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_out addr %0d data %h exp 0", out_addr, out_data);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_basic();
    drive(1, 0, 32'h0000_1234, 3'b010, 0, 5, 1, 1);
    tick();
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_addr !== 5'd5 || out_data !== 32'h0000_1234 || occupancy !== 2'd1) begin
      n_fail++;
      $display("FAIL basic got v%b a%0d d%h occ%0d exp v1 a5 d00001234 occ1", out_valid, out_addr, out_data, occupancy);
    end
    tick();
    n_tests++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_drain occ %0d valid %b exp 0", occupancy, out_valid);
    end
  endtask

  task automatic test_load_fmt();
    logic [2:0]  fmts[5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    int          offs[5] = '{3, 3, 2, 1, 1};
    logic [31:0] exps[5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
    for (int i = 0; i < 5; i++) begin
      drive(1, 2, 32'h80FF_7F01, fmts[i], offs[i], 9, 1, 1);
      tick();
      in_valid = 1'b0;
      #1;
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== exps[i]) begin
        n_fail++; $display("FAIL load_fmt[%0d] got %h (v%b) exp %h", i, out_data, out_valid, exps[i]);
      end
      tick();
    end
    // LOAD formatting must not touch other sources.
    drive(1, 1, 32'h80FF_7F01, 3'b000, 3, 4, 1, 1);
    tick();
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (out_data !== 32'h80FF_7F01) begin
      n_fail++; $display("FAIL const_passthru got %h exp 80ff7f01", out_data);
    end
    tick();
  endtask

  task automatic test_backpressure();
    for (int r = 1; r <= 2; r++) begin
      drive(1, 0, 32'h100 + r, 3'b010, 0, r, 1, 0);
      tick();
    end
    drive(1, 0, 32'h103, 3'b010, 0, 3, 1, 0);
    #1;
    n_tests++;
    if (in_ready !== 1'b0 || occupancy !== 2'd2) begin
      n_fail++; $display("FAIL bp_full in_ready %b occ %0d exp 0 2", in_ready, occupancy);
    end
    tick();
    out_ready = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      #1;
      n_tests++;
      if (out_valid !== 1'b1 || out_addr !== 5'(r) || out_data !== 32'h100 + r) begin
        n_fail++; $display("FAIL bp_order[%0d] got a%0d d%h v%b exp a%0d", r, out_addr, out_data, out_valid, r);
      end
      tick();
      if (r == 2) in_valid = 1'b0;
    end
    n_tests++;
    if (occupancy !== 2'd0 || q.size() != 0) begin
      n_fail++; $display("FAIL bp_drain occ %0d exp 0", occupancy);
    end
  endtask

  task automatic test_forwarding();
    drive(1, 0, 32'hA, 3'b010, 0, 7, 1, 0);
    tick();
    drive(1, 0, 32'hB, 3'b010, 0, 7, 1, 0);
    tick();
    in_valid  = 1'b0;
    fwd_raddr = 5'd7;
    #1;
    n_tests++;
    if (fwd_hit !== 1'b1 || fwd_data !== 32'hB) begin
      n_fail++; $display("FAIL fwd_newest hit %b data %h exp 1 b", fwd_hit, fwd_data);
    end
    fwd_raddr = 5'd0;
    #1;
    n_tests++;
    if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin
      n_fail++; $display("FAIL fwd_zero hit %b data %h exp 0 0", fwd_hit, fwd_data);
    end
    fwd_raddr = 5'd9;
    #1;
    n_tests++;
    if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin
      n_fail++; $display("FAIL fwd_miss hit %b data %h exp 0 0", fwd_hit, fwd_data);
    end
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_null();
    drive(1, 0, 32'h55, 3'b010, 0, 0, 1, 1);
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL null_ready got %b exp 1", in_ready); end
    tick();
    drive(1, 0, 32'h66, 3'b010, 0, 6, 0, 1);
    tick();
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL null_write v%b occ%0d rdy%b exp 0 0 1", out_valid, occupancy, in_ready);
    end
  endtask

  task automatic test_async_reset();
    int seen = 0;
    for (int r = 10; r <= 11; r++) begin
      drive(1, 0, 32'h200 + r, 3'b010, 0, r, 1, 0);
      tick();
    end
    in_valid = 1'b0;
    #2;
    n_tests++;
    if (occupancy !== 2'd2) begin n_fail++; $display("FAIL ar_pre occ %0d exp 2", occupancy); end
    rst_n = 1'b0;
    #1;
    q.delete();
    n_tests++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL ar_immediate v%b occ%0d rdy%b exp 0 0 0", out_valid, occupancy, in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid !== 1'b0) seen++;
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL ar_after cycles_with_valid %0d exp 0", seen); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bit          exp_hit;
      logic [31:0] exp_fd;
      drive(($urandom % 4) != 0, $urandom_range(0, 3), $urandom(), 3'($urandom),
            $urandom_range(0, 3), $urandom_range(0, 7), ($urandom % 5) != 0,
            ($urandom % 3) != 0);
      fwd_raddr = 5'($urandom_range(0, 7));
      #1;
      exp_hit = 1'b0;
      exp_fd  = 32'h0;
      if (fwd_raddr != 0) begin
        foreach (q[i]) if (q[i].a == fwd_raddr) begin exp_hit = 1'b1; exp_fd = q[i].d; end
      end
      n_tests++;
      if (in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0) || occupancy !== 2'(q.size())) begin
        n_fail++; $display("FAIL rand_ctrl c%0d rdy%b v%b occ%0d exp size %0d", c, in_ready, out_valid, occupancy, q.size());
      end
      if (q.size() > 0) begin
        n_tests++;
        if (out_addr !== q[0].a || out_data !== q[0].d) begin
          n_fail++; $display("FAIL rand_head c%0d got a%0d d%h exp a%0d d%h", c, out_addr, out_data, q[0].a, q[0].d);
        end
      end
      n_tests++;
      if (fwd_hit !== exp_hit || fwd_data !== exp_fd) begin
        n_fail++; $display("FAIL rand_fwd c%0d got %b %h exp %b %h", c, fwd_hit, fwd_data, exp_hit, exp_fd);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load_fmt();
    test_backpressure();
    test_forwarding();
    test_null();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
# writeback_stage

Parametrised register-file writeback stage for the pipelined core. It selects write data from NSRC result sources: ALU result, extended constant, formatted load data and PC+4. It aligns and extends sub-word load data, then buffers the resulting writes in a 2-entry skid queue with valid/ready handshakes on both sides. While writes wait in the queue it supplies forwarding data from the queued entries. The block sits between the execute/memory stages and the register-file write port; that write port may stall.

## Interface
- XLEN, 32: data width.
- NSRC, 4: number of write-data sources (minimum 2).
- REGW, 5: register address width.
- LOAD_SRC, 2: source index that receives load formatting.
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream write request valid
- in_ready  out  1  stage can accept a request
- src_data  in  NSRC*XLEN  packed sources, source i at bits [i*XLEN +: XLEN]
- src_sel  in  $clog2(NSRC)  source select
- load_fmt  in  3  RISC-V load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- byte_off  in  2  load address bits [1:0]
- rd_addr  in  REGW  destination register
- rd_we  in  1  write enable
- out_valid  out  1  write pending at register-file port
- out_ready  in  1  register file accepts the write
- out_addr  out  REGW  write address
- out_data  out  XLEN  write data
- fwd_raddr  in  REGW  forwarding query address
- fwd_hit  out  1  a queued entry matches fwd_raddr
- fwd_data  out  XLEN  data of the matching entry
- occupancy  out  2  queued entries, 0..2

## Operation
- Accept: in_valid && in_ready. Pop: out_valid && out_ready.
- Data select: src_sel < NSRC picks src_data[src_sel]. src_sel ≥ NSRC yields 0.
- Load formatting applies only when src_sel == LOAD_SRC.
  - Byte formats extract byte byte_off.
  - Halfword formats extract halfword byte_off[1]; byte_off[0] is ignored.
  - LB and LH sign-extend. LBU and LHU zero-extend.
  - LW, and any other funct3, passes the word unchanged.
- Null writes are accepted and discarded: no enqueue, no output. A write is null when rd_we == 0 or rd_addr == 0.
- Queue: 2 entries, FIFO order. Each entry holds {addr, data}.
- States:
  - EMPTY: push goes to ONE.
  - ONE: push only goes to TWO. Pop only goes to EMPTY. Push and pop together stays ONE.
  - TWO: pop goes to ONE.
- in_ready = (state != TWO) && rst_n. No push occurs in TWO.
- out_valid = (state != EMPTY). out_addr and out_data always show the oldest entry.
- Forwarding: combinational compare of fwd_raddr against valid entries. When both entries match, the newest entry wins. fwd_raddr == 0 never hits. With no match, fwd_hit = 0 and fwd_data = 0.
- occupancy tracks state: 0, 1 or 2.

## Timing
- Reset (rst_n low, asynchronous) clears:
  - state to EMPTY;
  - out_valid, fwd_hit and occupancy to 0;
  - out_addr and out_data to 0;
  - in_ready to 0 while reset is held, 1 from the first cycle after release.
- Latency: an entry accepted at edge N is visible on out_valid/out_data after edge N. Minimum one cycle from input to output.
- Throughput: 1 write per cycle while out_ready stays high.
- out_valid, out_addr and out_data hold stable until popped.
- Reset mid-operation drops all queued writes; nothing reaches the register file.
- A null write accepted together with a pop behaves as a pop only.

## Structure
- Package wb_pkg holds:
  - source index constants SRC_ALU=0, SRC_CONST=1, SRC_LOAD=2, SRC_PC4=3;
  - load funct3 constants LD_B, LD_H, LD_W, LD_BU, LD_HU;
  - the queue state enum {EMPTY, ONE, TWO}.
- One combinational sub-module, load_align, does the byte/halfword extraction and sign/zero extension (XLEN parameter).
- Queue storage and forwarding compare live in writeback_stage.

## Test plan
- Reset, then hold out_ready=1 and send src_sel=0 with src_data[0]=0x0000_1234, rd_addr=5 → next cycle out_valid=1, out_addr=5, out_data=0x0000_1234. occupancy returns to 0 after the pop.
- Load LB with src_sel=2, word 0x80FF_7F01, byte_off=3 → 0xFFFF_FF80. Same word as LBU with byte_off=3 → 0x0000_0080. Same word as LH with byte_off=2 → 0xFFFF_80FF.
- Hold out_ready=0 and push 3 writes to regs 1, 2, 3 → the first two are accepted, then in_ready=0 and occupancy=2. Release out_ready → outputs reg 1, then reg 2, then reg 3 after it is accepted.
- Queue regs 7 (data 0xA) and 7 (data 0xB) with out_ready=0, then query fwd_raddr=7 → fwd_hit=1, fwd_data=0xB. Query fwd_raddr=0 → fwd_hit=0.
- Send rd_addr=0 with rd_we=1, and separately rd_we=0 → in_ready stays 1, out_valid stays 0, occupancy stays 0.
- With occupancy=2, assert rst_n=0 asynchronously mid-cycle → out_valid=0 and occupancy=0 immediately, and no writes appear after release.
